smc_stream_rx: RTL

- Streaming receive front end for the saturation/triode MOSFET current (SMC) calculation.
- Accepts the six transistor parameter sets serially, one set per accepted beat, rather than as 18 parallel buses.
- Computes Id or gm per transistor on arrival and keeps a running descending-sorted buffer using insertion per beat.
- Emits the mode-selected weighted sum of the top three or bottom three values as a registered, one-cycle-valid result.

---
 rtl/smc_stream_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/smc_stream_rx.sv
// Serial-beat SMC receive front end: per-beat Id/gm, running descending insertion sort, weighted top/bottom-three sum.
// Optional idle-timeout abort inside a frame is enabled by defining SMC_TIMEOUT_EN.
module smc_stream_rx #(
  parameter int TIMEOUT_CYC = 15,
  parameter int N_TR        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] mode,
  input  logic [2:0] w,
  input  logic [2:0] v_gs,
  input  logic [2:0] v_ds,
  output logic       out_valid,
  output logic [9:0] out_n,
  output logic       out_err
);

  typedef enum logic [1:0] {IDLE, COLLECT, CALC, OUT} state_t;

  state_t     state;
  logic [2:0] beat_cnt;
  logic [1:0] mode_q;
  logic [6:0] sbuf [N_TR];
  logic [6:0] ins  [N_TR];

  logic [2:0] vt;
  logic [9:0] w10, vt10, vd10, num;
  logic [1:0] mode_cur;
  logic [6:0] val;

  // Beat 0 computes with the live mode since mode_q is only loaded on that same edge.
  always_comb begin
    vt       = v_gs - 3'd1;
    w10      = {7'd0, w};
    vt10     = {7'd0, vt};
    vd10     = {7'd0, v_ds};
    mode_cur = (state == IDLE) ? mode : mode_q;
    if (v_gs == 3'd0)
      num = '0;
    else if (vt > v_ds)
      num = mode_cur[0] ? w10 * ((vt10 << 1) - vd10) * vd10 : (w10 * vd10) << 1;
    else
      num = mode_cur[0] ? w10 * vt10 * vt10 : (w10 * vt10) << 1;
    val = 7'(num / 10'd3);
  end

  // Unfilled slots hold 0 and values are never negative, so a plain compare-and-shift suffices.
  genvar gi;
  generate
    for (gi = 0; gi < N_TR; gi++) begin : g_ins
      if (gi == 0) begin : g_head
        assign ins[gi] = (sbuf[0] >= val) ? sbuf[0] : val;
      end else begin : g_tail
        assign ins[gi] = (sbuf[gi] >= val) ? sbuf[gi] :
                         (sbuf[gi-1] >= val) ? val : sbuf[gi-1];
      end
    end
  endgenerate

  logic [6:0] sel_a, sel_b, sel_c;
  logic [9:0] sum;

  always_comb begin
    sel_a = mode_q[1] ? sbuf[0] : sbuf[3];
    sel_b = mode_q[1] ? sbuf[1] : sbuf[4];
    sel_c = mode_q[1] ? sbuf[2] : sbuf[5];
    if (mode_q[0])
      sum = 10'(sel_a) * 10'd3 + 10'(sel_b) * 10'd4 + 10'(sel_c) * 10'd5;
    else
      sum = 10'(sel_a) + 10'(sel_b) + 10'(sel_c);
  end

`ifdef SMC_TIMEOUT_EN
  localparam int IdleW = $clog2(TIMEOUT_CYC + 1);
  logic [IdleW-1:0] idle_cnt;
  logic             err_q;
  assign out_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      mode_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_n     <= '0;
      for (int i = 0; i < N_TR; i++) sbuf[i] <= '0;
`ifdef SMC_TIMEOUT_EN
      idle_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
`ifdef SMC_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q   <= mode;
            sbuf     <= ins;
            beat_cnt <= 3'd1;
            state    <= COLLECT;
`ifdef SMC_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        COLLECT: begin
          if (in_valid) begin
            sbuf     <= ins;
            beat_cnt <= beat_cnt + 3'd1;
`ifdef SMC_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (beat_cnt == 3'(N_TR - 1)) begin
              state    <= CALC;
              in_ready <= 1'b0;
            end
          end
`ifdef SMC_TIMEOUT_EN
          else if (idle_cnt == IdleW'(TIMEOUT_CYC - 1)) begin
            err_q    <= 1'b1;
            idle_cnt <= '0;
            beat_cnt <= '0;
            for (int i = 0; i < N_TR; i++) sbuf[i] <= '0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        CALC: begin
          out_n     <= sum;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          beat_cnt <= '0;
          for (int i = 0; i < N_TR; i++) sbuf[i] <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
